// File: rtl/display_pkg.sv
// Shared types and defaults for the display source scheduler.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    CONVERT = 2'd2,
    DWELL   = 2'd3
  } state_t;

  localparam int DEFAULT_DWELL   = 50_000_000;
  localparam int DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/rr_next_valid.sv
// Combinational round-robin search: first set valid bit after last_i, wrapping
// back to last_i itself.
module rr_next_valid #(
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] valid_i,
  input  logic [SEL_W-1:0]   last_i,
  output logic [SEL_W-1:0]   idx_o,
  output logic               found_o
);

  always_comb begin
    int cand;
    logic [SEL_W-1:0] cand_idx;
    cand     = 0;
    cand_idx = '0;
    idx_o    = last_i;
    found_o  = 1'b0;
    // Walk offsets from farthest to nearest so the nearest valid one wins.
    for (int k = NUM_SRC; k >= 1; k--) begin
      cand     = (int'(last_i) + k) % NUM_SRC;
      cand_idx = SEL_W'(cand);
      if (valid_i[cand_idx]) begin
        idx_o   = cand_idx;
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_source_scheduler.sv
// Time-shares one BCD/seven-segment converter among NUM_SRC value producers,
// rotating round-robin with a dwell period per source.
module display_source_scheduler
  import display_pkg::*;
#(
  parameter int NUM_SRC        = 4,
  parameter int VALUE_W        = 11,
  parameter int DWELL_CYCLES   = DEFAULT_DWELL,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  parameter int SEL_W          = $clog2(NUM_SRC)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_SRC*VALUE_W-1:0] src_value,
  input  logic [NUM_SRC-1:0]         src_valid,
  input  logic                       hold,
  output logic [VALUE_W-1:0]         conv_value,
  output logic                       conv_start,
  input  logic                       conv_done,
  output logic [SEL_W-1:0]           active_src,
  output logic                       display_update,
  output logic                       conv_timeout
);

  localparam int DWELL_W = $clog2(DWELL_CYCLES);
  localparam int TMO_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);

  // Converter handshake: conv_start is a one-cycle request with conv_value
  // stable from then until the next selection; conv_done is honoured only in
  // CONVERT, otherwise TIMEOUT_CYCLES later the request is abandoned.
  state_t               state_q;
  logic [SEL_W-1:0]     active_q;
  logic [VALUE_W-1:0]   value_q;
  logic                 start_q;
  logic                 update_q;
  logic                 timeout_q;
  logic [DWELL_W-1:0]   dwell_cnt_q;
  logic [TMO_W-1:0]     tmo_cnt_q;

  logic [SEL_W-1:0]     next_idx_d;
  logic                 next_found_d;
  logic [VALUE_W-1:0]   src_slice [NUM_SRC];

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
    assign src_slice[g] = src_value[g*VALUE_W +: VALUE_W];
  end

  rr_next_valid #(
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W)
  ) u_rr (
    .valid_i (src_valid),
    .last_i  (active_q),
    .idx_o   (next_idx_d),
    .found_o (next_found_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      active_q    <= SEL_W'(NUM_SRC - 1);
      value_q     <= '0;
      start_q     <= 1'b0;
      update_q    <= 1'b0;
      timeout_q   <= 1'b0;
      dwell_cnt_q <= '0;
      tmo_cnt_q   <= '0;
    end else begin
      start_q   <= 1'b0;
      update_q  <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (next_found_d) begin
            active_q <= next_idx_d;
            value_q  <= src_slice[next_idx_d];
            start_q  <= 1'b1;
            state_q  <= LOAD;
          end
        end
        LOAD: begin
          state_q <= CONVERT;
        end
        CONVERT: begin
          // done takes priority over a coincident timeout
          if (conv_done) begin
            update_q  <= 1'b1;
            tmo_cnt_q <= '0;
            state_q   <= DWELL;
          end else if (tmo_cnt_q == TMO_LAST) begin
            timeout_q <= 1'b1;
            tmo_cnt_q <= '0;
            state_q   <= DWELL;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        DWELL: begin
          if (!src_valid[active_q]) begin
            dwell_cnt_q <= '0;
            state_q     <= IDLE;
          end else if (dwell_cnt_q == DWELL_LAST) begin
            dwell_cnt_q <= '0;
            if (hold) begin
              value_q <= src_slice[active_q];
              start_q <= 1'b1;
              state_q <= LOAD;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            dwell_cnt_q <= dwell_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign conv_value     = value_q;
  assign conv_start     = start_q;
  assign active_src     = active_q;
  assign display_update = update_q;
  assign conv_timeout   = timeout_q;

endmodule

// File: tb/tb_display_source_scheduler.sv
// Bench for display_source_scheduler: procedural timeline model, per-cycle
// compare, conversion-value scoreboard, directed timing pins and random traffic.
module tb_display_source_scheduler;

  localparam int NUM_SRC = 4;
  localparam int VALUE_W = 11;
  localparam int DWELL   = 16;
  localparam int TMO     = 64;
  localparam int SEL_W   = 2;

  logic                       clk = 1'b0;
  logic                       reset = 1'b1;
  logic [NUM_SRC*VALUE_W-1:0] src_value = '0;
  logic [NUM_SRC-1:0]         src_valid = '0;
  logic                       hold = 1'b0;
  logic                       conv_done;
  logic [VALUE_W-1:0]         conv_value;
  logic                       conv_start;
  logic [SEL_W-1:0]           active_src;
  logic                       display_update;
  logic                       conv_timeout;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- clock / reset
  always #5 clk = ~clk;

  display_source_scheduler #(
    .NUM_SRC        (NUM_SRC),
    .VALUE_W        (VALUE_W),
    .DWELL_CYCLES   (DWELL),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .src_value      (src_value),
    .src_valid      (src_valid),
    .hold           (hold),
    .conv_value     (conv_value),
    .conv_start     (conv_start),
    .conv_done      (conv_done),
    .active_src     (active_src),
    .display_update (display_update),
    .conv_timeout   (conv_timeout)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: a timeline of the display schedule
  int                 m_active;
  logic [VALUE_W-1:0] m_value;
  bit                 m_start, m_update, m_timeout;
  bit                 rst_seen;
  logic [VALUE_W-1:0] exp_q[$];

  function automatic int pick_next(input logic [NUM_SRC-1:0] v, input int last);
    for (int k = 1; k <= NUM_SRC; k++)
      if (v[(last + k) % NUM_SRC]) return (last + k) % NUM_SRC;
    return -1;
  endfunction

  function automatic logic [VALUE_W-1:0] slice_of(input int i);
    return src_value[i*VALUE_W +: VALUE_W];
  endfunction

  task automatic model_clear();
    m_active  = NUM_SRC - 1;
    m_value   = '0;
    m_start   = 0;
    m_update  = 0;
    m_timeout = 0;
    exp_q.delete();
  endtask

  task automatic model_run();
    int p;
    bit got, relatch;
    forever begin
      p = -1;
      while (p < 0) begin
        @(posedge clk);
        if (reset || rst_seen) return;
        p = pick_next(src_valid, m_active);
      end
      m_active = p;
      m_value  = slice_of(p);
      m_start  = 1;
      exp_q.push_back(m_value);
      relatch = 1;
      while (relatch) begin
        relatch = 0;
        @(posedge clk);
        if (reset || rst_seen) return;
        m_start = 0;
        got = 0;
        for (int k = 0; k < TMO; k++) begin
          @(posedge clk);
          if (reset || rst_seen) return;
          if (conv_done) begin
            got = 1;
            break;
          end
        end
        if (got) m_update = 1;
        else     m_timeout = 1;
        for (int d = 0; d < DWELL; d++) begin
          @(posedge clk);
          if (reset || rst_seen) return;
          m_update  = 0;
          m_timeout = 0;
          if (!src_valid[m_active]) break;
          if (d == DWELL - 1 && hold) begin
            m_value = slice_of(m_active);
            m_start = 1;
            exp_q.push_back(m_value);
            relatch = 1;
          end
        end
      end
    end
  endtask

  always @(posedge reset) begin
    rst_seen = 1;
    model_clear();
  end

  initial begin
    forever begin
      model_clear();
      wait (reset === 1'b0);
      rst_seen = 0;
      model_run();
    end
  end

  // ---------------- per-cycle compare + scoreboard
  always @(negedge clk) begin
    #1;
    check("conv_start", 32'(conv_start), 32'(m_start));
    check("display_update", 32'(display_update), 32'(m_update));
    check("conv_timeout", 32'(conv_timeout), 32'(m_timeout));
    check("active_src", 32'(active_src), m_active);
    check("conv_value", 32'(conv_value), 32'(m_value));
    check("start_update_excl", 32'(conv_start & display_update), 32'd0);
    if (conv_start === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_underflow: got conv_start with value %0d, expected no start", conv_value);
      end else begin
        check("sb_conv_value", 32'(conv_value), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- converter model (mode 0: latency, 1: never, 2: noise)
  int conv_mode  = 0;
  int conv_fixed = 30;
  int conv_cnt   = -1;

  initial begin
    conv_done = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      conv_done = (conv_mode == 2) ? ($urandom_range(0, 5) == 0) : 1'b0;
      if (conv_start === 1'b1) begin
        if (conv_mode == 1) conv_cnt = -1;
        else conv_cnt = (conv_fixed > 0) ? conv_fixed : int'($urandom_range(1, 80));
      end else if (conv_cnt > 0) begin
        conv_cnt--;
        if (conv_cnt == 0) begin
          conv_done = 1'b1;
          conv_cnt  = -1;
        end
      end
    end
  end

  // ---------------- driver tasks
  task automatic set_src(input int i, input logic [VALUE_W-1:0] v);
    src_value[i*VALUE_W +: VALUE_W] = v;
  endtask

  // which: 0 conv_start, 1 display_update, 2 conv_timeout
  task automatic wait_sig(input string name, input int which, input int max_cyc, output int n);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if ((which == 0 && conv_start === 1'b1) ||
          (which == 1 && display_update === 1'b1) ||
          (which == 2 && conv_timeout === 1'b1)) return;
      if (n >= max_cyc) begin
        n_checks++;
        n_errors++;
        $display("FAIL %s: got no pulse, expected one within %0d cycles", name, max_cyc);
        return;
      end
    end
  endtask

  task automatic wait_start_on(input string name, input int src);
    int k;
    for (int i = 0; i < 8; i++) begin
      wait_sig(name, 0, 200, k);
      if (active_src == SEL_W'(src)) return;
    end
    n_checks++;
    n_errors++;
    $display("FAIL %s: got active_src %0d, expected %0d", name, active_src, src);
  endtask

  task automatic count_pulses(input int which, input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if ((which == 0 && conv_start === 1'b1) || (which == 1 && display_update === 1'b1)) cnt++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected one before 1ms");
    $fatal(1);
  end

  // ---------------- directed + random stimulus
  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_conv_value", 32'(conv_value), 0);
    check("rst_active_src", 32'(active_src), 3);
    check("rst_conv_start", 32'(conv_start), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // single source, 30-cycle converter
    set_src(0, 11'd1234);
    src_valid = 4'b0001;
    wait_sig("t1_start", 0, 10, n);
    check("t1_start_latency", n, 1);
    check("t1_value", 32'(conv_value), 1234);
    check("t1_active", 32'(active_src), 0);
    wait_sig("t1_update", 1, 100, n);
    check("t1_update_latency", n, 31);
    conv_fixed = 5;
    wait_sig("t1_repeat", 0, 100, n);
    check("t1_repeat_spacing", n, 17);
    check("t1_repeat_active", 32'(active_src), 0);

    // rotation over 1011, skipping source 2
    set_src(1, 11'd7);
    set_src(3, 11'd999);
    src_valid = 4'b1011;
    wait_sig("t2_a", 0, 200, n);
    check("t2_seq_a", 32'(active_src), 1);
    check("t2_spacing_a", n, 23);
    wait_sig("t2_b", 0, 200, n);
    check("t2_seq_b", 32'(active_src), 3);
    check("t2_value_b", 32'(conv_value), 999);
    check("t2_spacing_b", n, 23);
    wait_sig("t2_c", 0, 200, n);
    check("t2_seq_c", 32'(active_src), 0);
    check("t2_spacing_c", n, 23);

    // hold on source 1, value changed mid-dwell
    src_valid = 4'b0010;
    hold = 1'b1;
    wait_start_on("t3_sel", 1);
    check("t3_value_first", 32'(conv_value), 7);
    wait_sig("t3_update", 1, 100, n);
    repeat (5) @(negedge clk);
    set_src(1, 11'd2047);
    wait_sig("t3_refresh", 0, 100, n);
    check("t3_refresh_spacing", n, 11);
    check("t3_refresh_value", 32'(conv_value), 2047);
    check("t3_refresh_active", 32'(active_src), 1);
    for (int i = 0; i < 2; i++) begin
      wait_sig("t3_hold", 0, 100, n);
      check("t3_hold_spacing", n, 22);
      check("t3_hold_active", 32'(active_src), 1);
    end

    // converter that never answers
    hold = 1'b0;
    conv_mode = 1;
    src_valid = 4'b0001;
    wait_start_on("t4_sel", 0);
    wait_sig("t4_timeout", 2, 200, n);
    check("t4_timeout_latency", n, 65);
    wait_sig("t4_next", 0, 100, n);
    check("t4_next_spacing", n, 17);
    check("t4_next_active", 32'(active_src), 0);
    conv_mode = 0;

    // drop the active source at dwell count 5, then drop everything
    src_valid = 4'b0011;
    wait_sig("t5_update", 1, 100, n);
    check("t5_update_latency", n, 6);
    repeat (5) @(negedge clk);
    src_valid = 4'b0010;
    wait_sig("t5_next", 0, 20, n);
    check("t5_next_latency", n, 2);
    check("t5_next_active", 32'(active_src), 1);
    src_valid = 4'b0000;
    repeat (40) @(negedge clk);
    count_pulses(0, 60, n);
    check("t5_frozen_starts", n, 0);
    check("t5_frozen_value", 32'(conv_value), 2047);
    check("t5_frozen_active", 32'(active_src), 1);

    // reset during CONVERT, stale done afterwards
    conv_fixed = 8;
    src_valid = 4'b0001;
    wait_sig("t6_start", 0, 10, n);
    check("t6_start_latency", n, 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    src_valid = 4'b0000;
    @(negedge clk);
    check("t6_rst_active", 32'(active_src), 3);
    @(negedge clk);
    reset = 1'b0;
    count_pulses(1, 10, n);
    check("t6_stale_update", n, 0);
    src_valid = 4'b0101;
    wait_sig("t6_first", 0, 10, n);
    check("t6_first_latency", n, 1);
    check("t6_first_active", 32'(active_src), 0);

    // random traffic
    conv_fixed = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) set_src(int'($urandom_range(0, 3)), 11'($urandom_range(0, 2047)));
      if ($urandom_range(0, 39) == 0) src_valid = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 59) == 0) hold = ~hold;
      if ($urandom_range(0, 199) == 0) conv_mode = int'($urandom_range(0, 2));
      if ($urandom_range(0, 799) == 0) begin
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
      end
    end

    @(negedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
